// File: rtl/vga_pkg.sv
// Shared VGA timing constants, pixel width and frame-buffer sizing helpers
// used by the frame-buffer scheduler and its address generator.
package vga_pkg;

    localparam int H_TOTAL     = 800;
    localparam int V_TOTAL     = 525;
    localparam int H_ACTIVE    = 640;
    localparam int V_ACTIVE    = 480;
    localparam int SCALE_SHIFT = 2;
    localparam int PIX_W       = 12;
    localparam int CNT_W       = 11;

    // Kind of command loaded into the RAM command registers in a cycle
    typedef enum logic [1:0] {
        SLOT_IDLE  = 2'd0,
        SLOT_READ  = 2'd1,
        SLOT_WRITE = 2'd2
    } slot_t;

    function automatic int fb_w(input int h_active, input int shift);
        return h_active >> shift;
    endfunction

    function automatic int fb_h(input int v_active, input int shift);
        return v_active >> shift;
    endfunction

    // Smallest address width that can index the given number of words
    function automatic int addr_w_min(input int words);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < words) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    localparam int FB_W      = fb_w(H_ACTIVE, SCALE_SHIFT);
    localparam int FB_H      = fb_h(V_ACTIVE, SCALE_SHIFT);
    localparam int FB_ADDR_W = addr_w_min(FB_W * FB_H);

endpackage

// File: rtl/vga_fb_addr_gen.sv
// Combinational scanout address generator: from the driver counters it
// finds the decision cycle, the screen position being prefetched (with
// line/frame wrap), whether that position is visible, and its RAM address.
module vga_fb_addr_gen #(
    parameter int H_TOTAL     = vga_pkg::H_TOTAL,
    parameter int V_TOTAL     = vga_pkg::V_TOTAL,
    parameter int H_ACTIVE    = vga_pkg::H_ACTIVE,
    parameter int V_ACTIVE    = vga_pkg::V_ACTIVE,
    parameter int SCALE_SHIFT = vga_pkg::SCALE_SHIFT,
    parameter int ADDR_W      = vga_pkg::FB_ADDR_W
) (
    input  logic [vga_pkg::CNT_W-1:0] x,
    input  logic [vga_pkg::CNT_W-1:0] y,
    output logic                      is_decision,
    output logic                      fetch,
    output logic [ADDR_W-1:0]         fetch_addr
);
    import vga_pkg::*;

    localparam int CW    = CNT_W + 1;
    localparam int AW1   = ADDR_W + 1;
    localparam int BLOCK = 1 << SCALE_SHIFT;

    localparam logic [CW-1:0]          H_TOTAL_C  = CW'(H_TOTAL);
    localparam logic [CW-1:0]          V_TOTAL_C  = CW'(V_TOTAL);
    localparam logic [CW-1:0]          H_ACTIVE_C = CW'(H_ACTIVE);
    localparam logic [CW-1:0]          V_ACTIVE_C = CW'(V_ACTIVE);
    localparam logic [CW-1:0]          LEAD_C     = CW'(BLOCK - 1);
    localparam logic [SCALE_SHIFT-1:0] PHASE_D    = SCALE_SHIFT'(1);
    localparam logic [AW1-1:0]         FBW_C      = AW1'(fb_w(H_ACTIVE, SCALE_SHIFT));

    logic [CW-1:0]  tx_sum;
    logic [CW-1:0]  ty_inc;
    logic [CW-1:0]  tx;
    logic [CW-1:0]  ty;
    logic [AW1-1:0] addr_full;

    // Target is the first pixel of the next block; wrap into the next line/frame when past the line end
    always_comb begin
        tx_sum = {1'b0, x} + LEAD_C;
        ty_inc = {1'b0, y} + CW'(1);
        tx     = tx_sum;
        ty     = {1'b0, y};
        if (tx_sum >= H_TOTAL_C) begin
            tx = tx_sum - H_TOTAL_C;
            ty = (ty_inc == V_TOTAL_C) ? '0 : ty_inc;
        end
        is_decision = (x[SCALE_SHIFT-1:0] == PHASE_D);
        fetch       = is_decision && ({1'b0, x} < H_TOTAL_C)
                      && (tx < H_ACTIVE_C) && (ty < V_ACTIVE_C);
        addr_full   = AW1'(ty >> SCALE_SHIFT) * FBW_C + AW1'(tx >> SCALE_SHIFT);
        fetch_addr  = ADDR_W'(addr_full);
    end

endmodule

// File: rtl/vga_fb_scheduler.sv
// Time-slot arbiter for a single-port frame-buffer RAM shared by VGA
// scanout (fixed priority, one read per screen block) and a pixel writer
// that uses every remaining cycle.
module vga_fb_scheduler #(
    parameter int H_TOTAL     = vga_pkg::H_TOTAL,
    parameter int V_TOTAL     = vga_pkg::V_TOTAL,
    parameter int H_ACTIVE    = vga_pkg::H_ACTIVE,
    parameter int V_ACTIVE    = vga_pkg::V_ACTIVE,
    parameter int SCALE_SHIFT = vga_pkg::SCALE_SHIFT,
    parameter int ADDR_W      = vga_pkg::FB_ADDR_W
) (
    input  logic                      i_clk25m,
    input  logic                      i_rstn_clk25m,
    input  logic [vga_pkg::CNT_W-1:0] i_VGA_x,
    input  logic [vga_pkg::CNT_W-1:0] i_VGA_y,
    input  logic                      i_wr_req,
    input  logic [ADDR_W-1:0]         i_wr_addr,
    input  logic [vga_pkg::PIX_W-1:0] i_wr_data,
    output logic                      o_wr_ack,
    output logic                      o_fb_en,
    output logic                      o_fb_we,
    output logic [ADDR_W-1:0]         o_fb_addr,
    output logic [vga_pkg::PIX_W-1:0] o_fb_wdata,
    input  logic [vga_pkg::PIX_W-1:0] i_fb_rdata,
    output logic [vga_pkg::PIX_W-1:0] o_pixel_data
);
    import vga_pkg::*;

    logic              is_decision;
    logic              fetch;
    logic [ADDR_W-1:0] fetch_addr;
    slot_t             slot;
    logic              dec_p1;
    logic              dec_p2;
    logic              rd_p1;
    logic              rd_p2;

    vga_fb_addr_gen #(
        .H_TOTAL     (H_TOTAL),
        .V_TOTAL     (V_TOTAL),
        .H_ACTIVE    (H_ACTIVE),
        .V_ACTIVE    (V_ACTIVE),
        .SCALE_SHIFT (SCALE_SHIFT),
        .ADDR_W      (ADDR_W)
    ) u_addr_gen (
        .x           (i_VGA_x),
        .y           (i_VGA_y),
        .is_decision (is_decision),
        .fetch       (fetch),
        .fetch_addr  (fetch_addr)
    );

    // Scanout owns the slot whenever a fetch is due; otherwise a pending write is accepted and acked
    always_comb begin
        slot     = SLOT_IDLE;
        o_wr_ack = 1'b0;
        if (fetch) begin
            slot = SLOT_READ;
        end else if (i_wr_req && i_rstn_clk25m) begin
            slot     = SLOT_WRITE;
            o_wr_ack = 1'b1;
        end
    end

    // Register the chosen RAM command; address and write data hold through idle cycles
    always_ff @(posedge i_clk25m or negedge i_rstn_clk25m) begin
        if (!i_rstn_clk25m) begin
            o_fb_en    <= 1'b0;
            o_fb_we    <= 1'b0;
            o_fb_addr  <= '0;
            o_fb_wdata <= '0;
        end else begin
            case (slot)
                SLOT_READ: begin
                    o_fb_en   <= 1'b1;
                    o_fb_we   <= 1'b0;
                    o_fb_addr <= fetch_addr;
                end
                SLOT_WRITE: begin
                    o_fb_en    <= 1'b1;
                    o_fb_we    <= 1'b1;
                    o_fb_addr  <= i_wr_addr;
                    o_fb_wdata <= i_wr_data;
                end
                default: begin
                    o_fb_en <= 1'b0;
                    o_fb_we <= 1'b0;
                end
            endcase
        end
    end

    // Track decision cycles to the data-return cycle; capture RAM data only for a pending read, else black
    always_ff @(posedge i_clk25m or negedge i_rstn_clk25m) begin
        if (!i_rstn_clk25m) begin
            dec_p1       <= 1'b0;
            dec_p2       <= 1'b0;
            rd_p1        <= 1'b0;
            rd_p2        <= 1'b0;
            o_pixel_data <= '0;
        end else begin
            dec_p1 <= is_decision;
            rd_p1  <= fetch;
            dec_p2 <= dec_p1;
            rd_p2  <= rd_p1;
            if (dec_p2) begin
                o_pixel_data <= rd_p2 ? i_fb_rdata : '0;
            end
        end
    end

endmodule

// File: tb/tb_vga_fb_scheduler.sv
// Self-checking bench for vga_fb_scheduler: a behavioural RAM, a writer that
// holds requests until acked, and a screen-position reference model.
module tb_vga_fb_scheduler;

    localparam int HT  = 800;
    localparam int VT  = 525;
    localparam int HA  = 640;
    localparam int VA  = 480;
    localparam int FBW = 160;

    logic        clk = 1'b0;
    logic        rstn;
    logic [10:0] vga_x;
    logic [10:0] vga_y;
    logic        wr_req;
    logic [14:0] wr_addr;
    logic [11:0] wr_data;
    logic        wr_ack;
    logic        fb_en;
    logic        fb_we;
    logic [14:0] fb_addr;
    logic [11:0] fb_wdata;
    logic [11:0] fb_rdata;
    logic [11:0] pixel;

    always #5 clk = ~clk;

    vga_fb_scheduler dut (
        .i_clk25m      (clk),
        .i_rstn_clk25m (rstn),
        .i_VGA_x       (vga_x),
        .i_VGA_y       (vga_y),
        .i_wr_req      (wr_req),
        .i_wr_addr     (wr_addr),
        .i_wr_data     (wr_data),
        .o_wr_ack      (wr_ack),
        .o_fb_en       (fb_en),
        .o_fb_we       (fb_we),
        .o_fb_addr     (fb_addr),
        .o_fb_wdata    (fb_wdata),
        .i_fb_rdata    (fb_rdata),
        .o_pixel_data  (pixel)
    );

    // Initial RAM contents, a fixed function of the address
    function automatic logic [11:0] ram_seed(input int a);
        return 12'((a * 37 + 5) % 4096);
    endfunction

    // Behavioural single-port RAM with one-cycle registered read
    bit [11:0] ram [0:32767];
    always @(posedge clk) begin
        if (fb_en) begin
            if (fb_we) ram[fb_addr] <= fb_wdata ^ ram_seed(int'(fb_addr));
            else       fb_rdata     <= ram[fb_addr] ^ ram_seed(int'(fb_addr));
        end
    end

    typedef struct {
        int          due;
        logic [11:0] val;
    } pend_t;

    int          passed = 0;
    int          failed = 0;
    int          total  = 0;
    int          cyc    = 0;
    int          acks   = 0;
    int          reads  = 0;
    int          cur_x, cur_y, w_addr, wmode;
    bit          cur_rstn, w_req, e_en, e_we, last_ack, prev_idle, found;
    logic [11:0] w_data, e_wdata, exp_pix;
    logic [14:0] e_addr;
    logic [11:0] mm [int];
    pend_t       pq [$];

    function automatic logic [11:0] model_read(input int a);
        if (mm.exists(a)) return mm[a];
        return ram_seed(a);
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One pixel clock: drive inputs, predict, clock, compare
    task automatic apply_stimulus();
        int lin, tx, ty, faddr;
        bit phase_d, fetch, e_ack;
        rstn    = cur_rstn;
        vga_x   = 11'(cur_x);
        vga_y   = 11'(cur_y);
        wr_req  = w_req;
        wr_addr = 15'(w_addr);
        wr_data = w_data;
        #1;
        e_ack = 1'b0;
        if (!cur_rstn) begin
            check_output("rst_en",    32'(fb_en),    32'd0);
            check_output("rst_we",    32'(fb_we),    32'd0);
            check_output("rst_addr",  32'(fb_addr),  32'd0);
            check_output("rst_wdata", 32'(fb_wdata), 32'd0);
            check_output("rst_pixel", 32'(pixel),    32'd0);
        end else begin
            phase_d = (cur_x % 4) == 1;
            lin = cur_y * HT + cur_x + 3;
            if (lin >= HT * VT) lin -= HT * VT;
            tx = lin % HT;
            ty = lin / HT;
            fetch = phase_d && (cur_x < HT) && (tx < HA) && (ty < VA);
            faddr = (ty / 4) * FBW + tx / 4;
            e_ack = w_req && !fetch;
            if (phase_d) pq.push_back('{due: cyc, val: (fetch ? model_read(faddr) : 12'h000)});
            if (fetch) begin
                e_en = 1'b1; e_we = 1'b0; e_addr = 15'(faddr);
            end else if (w_req) begin
                e_en = 1'b1; e_we = 1'b1; e_addr = 15'(w_addr); e_wdata = w_data;
                mm[w_addr] = w_data;
            end else begin
                e_en = 1'b0; e_we = 1'b0;
            end
        end
        check_output("wr_ack", 32'(wr_ack), 32'(e_ack));
        last_ack = wr_ack;
        acks += int'(wr_ack);
        @(posedge clk);
        cyc++;
        if (!cur_rstn) begin
            e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0; exp_pix = '0;
            pq.delete();
        end
        while (pq.size() > 0 && pq[0].due + 3 <= cyc) begin
            exp_pix = pq[0].val;
            void'(pq.pop_front());
        end
        @(negedge clk);
        check_output("fb_en",    32'(fb_en),    32'(e_en));
        check_output("fb_we",    32'(fb_we),    32'(e_we));
        check_output("fb_addr",  32'(fb_addr),  32'(e_addr));
        check_output("fb_wdata", 32'(fb_wdata), 32'(e_wdata));
        check_output("pixel",    32'(pixel),    32'(exp_pix));
        if (fb_en && !fb_we) reads++;
        if (e_ack || !w_req) begin
            w_addr = int'($urandom_range(32767));
            w_data = 12'($urandom);
            case (wmode)
                2:       w_req = 1'b1;
                1:       w_req = bit'($urandom_range(1));
                default: w_req = 1'b0;
            endcase
        end
        cur_x++;
        if (cur_x == HT) begin
            cur_x = 0;
            cur_y = (cur_y == VT - 1) ? 0 : cur_y + 1;
        end
    endtask

    initial begin
        rstn = 1'b1; cur_rstn = 1'b0;
        vga_x = '0; vga_y = '0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0; exp_pix = '0;
        w_req = 1'b0; w_addr = 0; w_data = '0; wmode = 1; cur_x = 0; cur_y = 0;
        #1 rstn = 1'b0;
        @(negedge clk);

        // Reset held with random counters and requests
        for (int i = 0; i < 6; i++) begin
            cur_x = int'($urandom_range(HT - 1));
            cur_y = int'($urandom_range(VT - 1));
            w_req = bit'($urandom_range(1));
            apply_stimulus();
        end

        // Release at the start of the frame with no writer activity
        cur_rstn = 1'b1; cur_x = 0; cur_y = 0; wmode = 0; w_req = 1'b0;
        apply_stimulus();
        check_output("first_idle_en", 32'(fb_en), 32'd0);
        apply_stimulus();
        check_output("first_fetch_en",   32'(fb_en),   32'd1);
        check_output("first_fetch_we",   32'(fb_we),   32'd0);
        check_output("first_fetch_addr", 32'(fb_addr), 32'd1);

        // Plant a known pixel, then fetch it at the start of line 10
        cur_x = 100; cur_y = 200; w_req = 1'b1; w_addr = 320; w_data = 12'hABC;
        apply_stimulus();
        check_output("plant_we",    32'(fb_we),    32'd1);
        check_output("plant_wdata", 32'(fb_wdata), 32'hABC);
        apply_stimulus();
        cur_x = 797; cur_y = 9;
        apply_stimulus();
        check_output("line_start_en",   32'(fb_en),   32'd1);
        check_output("line_start_we",   32'(fb_we),   32'd0);
        check_output("line_start_addr", 32'(fb_addr), 32'd320);
        apply_stimulus();
        for (int i = 0; i < 4; i++) begin
            apply_stimulus();
            check_output("line_start_pix", 32'(pixel), 32'hABC);
        end

        // Last visible block of the frame, then the right border
        cur_x = 633; cur_y = 479;
        apply_stimulus();
        check_output("last_addr", 32'(fb_addr), 32'd19199);
        for (int i = 0; i < 6; i++) apply_stimulus();
        check_output("border_pix", 32'(pixel), 32'd0);

        // Active line with a continuous writer
        cur_x = 0; cur_y = 100; wmode = 2; w_req = 1'b1; acks = 0; reads = 0;
        for (int i = 0; i < HT; i++) apply_stimulus();
        check_output("active_acks",  32'(acks),  32'd640);
        check_output("active_reads", 32'(reads), 32'd160);

        // Vertical blank with a continuous writer
        cur_x = 0; cur_y = 500; acks = 0; reads = 0;
        for (int i = 0; i < HT; i++) apply_stimulus();
        check_output("vblank_acks",  32'(acks),  32'd800);
        check_output("vblank_reads", 32'(reads), 32'd0);

        // Random writer across the frame wrap
        cur_x = 600; cur_y = 523; wmode = 1;
        for (int i = 0; i < 400; i++) apply_stimulus();

        // Quiet the writer, then reset at a fetch decision with a new request pending
        cur_x = 40; cur_y = 50; wmode = 0; prev_idle = 1'b0; found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if ((cur_x % 4) == 1 && prev_idle) begin
                found = 1'b1;
                break;
            end
            prev_idle = !w_req;
            apply_stimulus();
        end
        check_output("reset_point_found", 32'(found), 32'd1);
        cur_rstn = 1'b0; w_req = 1'b1;
        w_addr = int'($urandom_range(32767)); w_data = 12'($urandom);
        for (int i = 0; i < 4; i++) apply_stimulus();
        cur_rstn = 1'b1;
        apply_stimulus();
        check_output("post_rst_d_ack", 32'(last_ack), 32'd0);
        apply_stimulus();
        check_output("post_rst_ack", 32'(last_ack), 32'd1);
        wmode = 1;
        for (int i = 0; i < 80; i++) apply_stimulus();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
